// File: rtl/updn_chan_sel.sv
// Debounced UP/DN switch channel selector with wrap/saturate, optional skip range and parallel load.
// Two switch lanes share one debounce sub-module; the channel register sits in the top.

module updn_chan_sel_deb #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

    logic [1:0]    sync;
    logic          deb, deb_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], raw};
            deb_q <= deb;
            // counter only runs while the synced level disagrees with the accepted level
            if (sync[1] != deb) begin
                if (cnt == CW'(DEB_CYC - 1)) begin
                    deb <= sync[1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = deb & ~deb_q;
endmodule

module updn_chan_sel #(
    parameter int WIDTH   = 8,
    parameter int CNT_MIN = 0,
    parameter int CNT_MAX = 4,
    parameter int DEF     = 0,
    parameter int WRAP    = 1,
    parameter int DEB_CYC = 4,
    parameter int SKIP_EN = 0,
    parameter int SKIP_LO = 14,
    parameter int SKIP_HI = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] chan,
    output logic             chan_stb,
    output logic             at_min,
    output logic             at_max,
    output logic             limit_hit
);
    localparam int NUM_LANES = 2;
    localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(CNT_MIN);
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(CNT_MAX);
    localparam logic [WIDTH:0] DEF_X = (WIDTH+1)'(DEF);
    localparam logic [WIDTH:0] SLO_X = (WIDTH+1)'(SKIP_LO);
    localparam logic [WIDTH:0] SHI_X = (WIDTH+1)'(SKIP_HI);

    logic [NUM_LANES-1:0] raw, rise;
    logic [WIDTH:0]       cur, nxt, ld_x;
    logic                 stb_n, lim_n, ev_up, ev_dn;

    assign raw = {dn, up};

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            updn_chan_sel_deb #(.DEB_CYC(DEB_CYC)) u_deb (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw[g]),
                .rise (rise[g])
            );
        end
    endgenerate

    assign ev_up = rise[0];
    assign ev_dn = rise[1];

    function automatic logic in_skip(input logic [WIDTH:0] v);
        return (SKIP_EN != 0) && (v >= SLO_X) && (v <= SHI_X);
    endfunction

    assign cur  = {1'b0, chan};
    assign ld_x = {1'b0, load_val};

    always_comb begin
        nxt   = cur;
        stb_n = 1'b0;
        lim_n = 1'b0;
        if (load) begin
            stb_n = 1'b1;
            nxt   = (ld_x >= MIN_X && ld_x <= MAX_X && !in_skip(ld_x)) ? ld_x : DEF_X;
        end else if (ev_up ^ ev_dn) begin
            // a refused saturating step still strobes, with chan unchanged
            stb_n = 1'b1;
            if (ev_up) begin
                if (cur == MAX_X) begin
                    if (WRAP != 0) nxt = MIN_X;
                    else           lim_n = 1'b1;
                end else begin
                    nxt = cur + 1'b1;
                    if (in_skip(nxt)) nxt = SHI_X + 1'b1;
                end
            end else begin
                if (cur == MIN_X) begin
                    if (WRAP != 0) nxt = MAX_X;
                    else           lim_n = 1'b1;
                end else begin
                    nxt = cur - 1'b1;
                    if (in_skip(nxt)) nxt = SLO_X - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan      <= DEF_X[WIDTH-1:0];
            chan_stb  <= 1'b0;
            limit_hit <= 1'b0;
        end else begin
            chan      <= nxt[WIDTH-1:0];
            chan_stb  <= stb_n;
            limit_hit <= lim_n;
        end
    end

    assign at_min = (chan == MIN_X[WIDTH-1:0]);
    assign at_max = (chan == MAX_X[WIDTH-1:0]);
endmodule

// File: tb/tb_updn_chan_sel.sv
// Directed bench for updn_chan_sel: three instances (wrap, saturate, skip) on one clock.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.

module tb_updn_chan_sel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] up = '0, dn = '0, load = '0;
    logic [7:0] load_val [3];
    logic [7:0] chan [3];
    logic [2:0] stb, amin, amax, lim;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    // inst 0: wrap, DEF=2
    updn_chan_sel #(.WIDTH(8), .CNT_MIN(0), .CNT_MAX(4), .DEF(2), .WRAP(1), .DEB_CYC(4)) u_wrap (
        .clk(clk), .rst(rst), .up(up[0]), .dn(dn[0]), .load(load[0]), .load_val(load_val[0]),
        .chan(chan[0]), .chan_stb(stb[0]), .at_min(amin[0]), .at_max(amax[0]), .limit_hit(lim[0]));
    // inst 1: saturate
    updn_chan_sel #(.WIDTH(8), .CNT_MIN(0), .CNT_MAX(4), .DEF(0), .WRAP(0), .DEB_CYC(4)) u_sat (
        .clk(clk), .rst(rst), .up(up[1]), .dn(dn[1]), .load(load[1]), .load_val(load_val[1]),
        .chan(chan[1]), .chan_stb(stb[1]), .at_min(amin[1]), .at_max(amax[1]), .limit_hit(lim[1]));
    // inst 2: skip 14..15, max 20
    updn_chan_sel #(.WIDTH(8), .CNT_MIN(0), .CNT_MAX(20), .DEF(0), .WRAP(1), .DEB_CYC(4),
                    .SKIP_EN(1), .SKIP_LO(14), .SKIP_HI(15)) u_skip (
        .clk(clk), .rst(rst), .up(up[2]), .dn(dn[2]), .load(load[2]), .load_val(load_val[2]),
        .chan(chan[2]), .chan_stb(stb[2]), .at_min(amin[2]), .at_max(amax[2]), .limit_hit(lim[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // drive the switch(es) and stop at the falling edge after edge DEB_CYC+3
    task automatic press(input int i, input logic u, input logic d);
        @(posedge clk); #1;
        up[i] = u; dn[i] = d;
        repeat (7) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_sw(input int i);
        @(posedge clk); #1;
        up[i] = 1'b0; dn[i] = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    // returns at the falling edge right after the load was taken
    task automatic ld(input int i, input logic [7:0] v);
        @(posedge clk); #1;
        load[i] = 1'b1; load_val[i] = v;
        @(posedge clk); #1;
        load[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nstb;
        for (int i = 0; i < 3; i++) load_val[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        // T1 reset values
        chk("rst_chan_a", chan[0], 2);
        chk("rst_stb_a", stb[0], 0);
        chk("rst_amin_a", amin[0], 0);
        chk("rst_lim_a", lim[0], 0);
        chk("rst_chan_b", chan[1], 0);
        chk("rst_amin_b", amin[1], 1);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // T2 3-cycle glitch ignored
        @(posedge clk); #1;
        up[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 up[0] = 1'b0;
        nstb = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (stb[0]) nstb++;
        end
        chk("glitch_stb", nstb, 0);
        chk("glitch_chan", chan[0], 2);

        // T2 held press: update lands at edge 7, strobe one cycle wide
        @(posedge clk); #1;
        up[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 6) begin
                chk("lat_e6_chan", chan[0], 2);
                chk("lat_e6_stb", stb[0], 0);
            end
            if (k == 7) begin
                chk("lat_e7_chan", chan[0], 3);
                chk("lat_e7_stb", stb[0], 1);
            end
            if (k == 8) chk("lat_e8_stb", stb[0], 0);
        end
        release_sw(0);
        chk("release_chan", chan[0], 3);

        // T3 wrap both ways
        ld(0, 8'd4);
        chk("ld4_chan", chan[0], 4);
        chk("ld4_stb", stb[0], 1);
        chk("ld4_amax", amax[0], 1);
        press(0, 1'b1, 1'b0);
        chk("wrap_up_chan", chan[0], 0);
        chk("wrap_up_amin", amin[0], 1);
        chk("wrap_up_lim", lim[0], 0);
        release_sw(0);
        press(0, 1'b0, 1'b1);
        chk("wrap_dn_chan", chan[0], 4);
        chk("wrap_dn_amax", amax[0], 1);
        release_sw(0);

        // T4 saturate
        ld(1, 8'd4);
        press(1, 1'b1, 1'b0);
        chk("sat_up_chan", chan[1], 4);
        chk("sat_up_stb", stb[1], 1);
        chk("sat_up_lim", lim[1], 1);
        @(negedge clk);
        chk("sat_up_lim_end", lim[1], 0);
        chk("sat_up_stb_end", stb[1], 0);
        release_sw(1);
        ld(1, 8'd0);
        press(1, 1'b0, 1'b1);
        chk("sat_dn_chan", chan[1], 0);
        chk("sat_dn_lim", lim[1], 1);
        release_sw(1);
        ld(1, 8'd3);
        press(1, 1'b1, 1'b0);
        chk("sat_mid_chan", chan[1], 4);
        chk("sat_mid_lim", lim[1], 0);
        release_sw(1);

        // T5 skip range and illegal loads
        ld(2, 8'd13);
        chk("skip_ld13", chan[2], 13);
        press(2, 1'b1, 1'b0);
        chk("skip_up", chan[2], 16);
        release_sw(2);
        press(2, 1'b0, 1'b1);
        chk("skip_dn", chan[2], 13);
        release_sw(2);
        ld(2, 8'd15);
        chk("skip_ld15", chan[2], 0);
        chk("skip_ld15_stb", stb[2], 1);
        ld(2, 8'd20);
        chk("skip_ld20", chan[2], 20);
        chk("skip_ld20_amax", amax[2], 1);
        ld(2, 8'd21);
        chk("skip_ld21", chan[2], 0);

        // T6 simultaneous up/dn: nothing happens
        ld(0, 8'd2);
        press(0, 1'b1, 1'b1);
        chk("both_chan", chan[0], 2);
        chk("both_stb", stb[0], 0);
        release_sw(0);

        // T6 load in the same cycle as an up event wins
        @(posedge clk); #1;
        up[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 load[0] = 1'b1; load_val[0] = 8'd1;
        @(posedge clk); #1;
        load[0] = 1'b0;
        @(negedge clk);
        chk("ldup_chan", chan[0], 1);
        chk("ldup_stb", stb[0], 1);
        nstb = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (stb[0]) nstb++;
        end
        chk("ldup_drop_stb", nstb, 0);
        chk("ldup_drop_chan", chan[0], 1);
        release_sw(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
